motor_pwm_multi: RTL and testbench

//  Parametrised N-channel H-bridge motor driver; successor to the fixed 2-bit, 50%-duty driver.
//  - Per-channel programmable duty and soft acceleration ramp.
//  - Safe direction reversal: ramp down, then dead time, then re-enable.
//  - All channels share one PWM period counter.
//  - Sits between the motion-control logic and the bridge pins; runs on the 100 kHz system tick.

---
 rtl/motor_pkg.sv | 30 +++
 rtl/motor_channel.sv | 138 +++++++++++++
 rtl/motor_pwm_multi.sv | 56 +++++
 tb/tb_motor_pwm_multi.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared state, direction and bridge-enable codes for the motor PWM driver
package motor_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        RAMP_DN = 2'd2,
        DEAD    = 2'd3
    } state_t;

    localparam logic [1:0] DIR_FWD = 2'b11;
    localparam logic [1:0] DIR_REV = 2'b00;

    localparam logic [1:0] EN_FWD = 2'b10;
    localparam logic [1:0] EN_REV = 2'b01;
    localparam logic [1:0] EN_OFF = 2'b00;

    function automatic logic is_move(input logic [1:0] d);
        return (d == DIR_FWD) || (d == DIR_REV);
    endfunction

    // Only driving states may enable a bridge leg, so en==11 cannot be produced.
    function automatic logic [1:0] en_code(input state_t s, input logic [1:0] d);
        if ((s == RUN) || (s == RAMP_DN)) begin
            return (d == DIR_FWD) ? EN_FWD : EN_REV;
        end
        return EN_OFF;
    endfunction

endpackage

// File: rtl/motor_channel.sv
// rtl/motor_channel.sv - one H-bridge channel: direction FSM, duty ramp, dead time, en/pwm registers
// MOTOR_SOFT_RAMP_EN enables the soft ramp and ramp-down before reversal.
module motor_channel
    import motor_pkg::*;
#(
    parameter int PERIOD    = 1000,
    parameter int DUTY_W    = 10,
    parameter int RAMP_STEP = 10,
    parameter int DEADTIME  = 100,
    parameter int CNT_W     = 10
) (
    input  logic              clk_100kHz,
    input  logic              rst,
    input  logic [CNT_W-1:0]  cnt_nxt,
    input  logic              boundary,
    input  logic [1:0]        direction,
    input  logic [DUTY_W-1:0] duty_target,
    output logic [1:0]        en,
    output logic              pwm,
    output logic              busy
);
`ifdef MOTOR_SOFT_RAMP_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif
    localparam int DW   = DUTY_W + 1;
    localparam int DT_W = $clog2(DEADTIME + 1);
    // A full-period step reaches any clamped target in a single boundary.
    localparam logic [DUTY_W:0] STEP_E  = DW'(SOFT ? RAMP_STEP : PERIOD);
    localparam logic [DUTY_W:0] PER_E   = DW'(PERIOD);
    localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEADTIME);

    state_t            state, state_nxt;
    logic [1:0]        dir_cur, dir_nxt;
    logic [DUTY_W-1:0] duty_cur, duty_nxt;
    logic [DT_W-1:0]   dead_cnt, dead_nxt;
    logic [DUTY_W:0]   cur_e, tgt_e, toward, down;
    logic              halt, opposite;

    always_comb begin
        cur_e = DW'(duty_cur);
        tgt_e = (DW'(duty_target) > PER_E) ? PER_E : DW'(duty_target);
        if (cur_e + STEP_E <= tgt_e) begin
            toward = cur_e + STEP_E;
        end else if (cur_e > tgt_e + STEP_E) begin
            toward = cur_e - STEP_E;
        end else begin
            toward = tgt_e;
        end
        down     = (cur_e > STEP_E) ? (cur_e - STEP_E) : '0;
        halt     = !is_move(direction);
        opposite = is_move(direction) && (direction != dir_cur);
    end

    always_comb begin
        state_nxt = state;
        dir_nxt   = dir_cur;
        duty_nxt  = duty_cur;
        dead_nxt  = dead_cnt;
        case (state)
            IDLE: begin
                duty_nxt = '0;
                if (!halt) begin
                    state_nxt = RUN;
                    dir_nxt   = direction;
                end
            end
            RUN: begin
                if (halt) begin
                    state_nxt = IDLE;
                    duty_nxt  = '0;
                end else if (opposite) begin
                    if (SOFT) begin
                        state_nxt = RAMP_DN;
                    end else begin
                        state_nxt = DEAD;
                        dead_nxt  = DT_LOAD;
                        duty_nxt  = '0;
                    end
                end else if (boundary) begin
                    duty_nxt = DUTY_W'(toward);
                end
            end
            RAMP_DN: begin
                if (halt) begin
                    state_nxt = IDLE;
                    duty_nxt  = '0;
                end else if (!opposite) begin
                    state_nxt = RUN;
                end else if (boundary) begin
                    duty_nxt = DUTY_W'(down);
                    if (down == '0) begin
                        state_nxt = DEAD;
                        dead_nxt  = DT_LOAD;
                    end
                end
            end
            DEAD: begin
                duty_nxt = '0;
                if (halt) begin
                    state_nxt = IDLE;
                end else if (dead_cnt <= DT_W'(1)) begin
                    state_nxt = RUN;
                    dir_nxt   = direction;
                end else begin
                    dead_nxt = dead_cnt - DT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // pwm and en are registered from the next state so they stay aligned with cnt.
    always_ff @(posedge clk_100kHz or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            dir_cur  <= DIR_REV;
            duty_cur <= '0;
            dead_cnt <= '0;
            en       <= EN_OFF;
            pwm      <= 1'b0;
        end else begin
            state    <= state_nxt;
            dir_cur  <= dir_nxt;
            duty_cur <= duty_nxt;
            dead_cnt <= dead_nxt;
            en       <= en_code(state_nxt, dir_nxt);
            pwm      <= ((state_nxt == RUN) || (state_nxt == RAMP_DN)) &&
                        (DW'(cnt_nxt) < DW'(duty_nxt));
        end
    end

    always_comb begin
        busy = (state == RAMP_DN) || (state == DEAD) || ((state == RUN) && (cur_e != tgt_e));
    end

endmodule

// File: rtl/motor_pwm_multi.sv
// rtl/motor_pwm_multi.sv - N-channel H-bridge PWM driver with a shared period counter
// Soft ramp and ramp-down reversal are selected with MOTOR_SOFT_RAMP_EN.
module motor_pwm_multi
    import motor_pkg::*;
#(
    parameter int CHANNELS  = 2,
    parameter int PERIOD    = 1000,
    parameter int DUTY_W    = 10,
    parameter int RAMP_STEP = 10,
    parameter int DEADTIME  = 100
) (
    input  logic                       clk_100kHz,
    input  logic                       rst,
    input  logic [2*CHANNELS-1:0]      direction,
    input  logic [DUTY_W*CHANNELS-1:0] duty_target,
    output logic [2*CHANNELS-1:0]      en,
    output logic [CHANNELS-1:0]        pwm,
    output logic                       period_sync,
    output logic [CHANNELS-1:0]        busy
);
    localparam int CNT_W = $clog2(PERIOD);

    logic [CNT_W-1:0] cnt, cnt_nxt;

    assign period_sync = (cnt == CNT_W'(PERIOD - 1));
    assign cnt_nxt     = period_sync ? '0 : cnt + CNT_W'(1);

    always_ff @(posedge clk_100kHz or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        motor_channel #(
            .PERIOD    (PERIOD),
            .DUTY_W    (DUTY_W),
            .RAMP_STEP (RAMP_STEP),
            .DEADTIME  (DEADTIME),
            .CNT_W     (CNT_W)
        ) u_ch (
            .clk_100kHz  (clk_100kHz),
            .rst         (rst),
            .cnt_nxt     (cnt_nxt),
            .boundary    (period_sync),
            .direction   (direction[2*c +: 2]),
            .duty_target (duty_target[DUTY_W*c +: DUTY_W]),
            .en          (en[2*c +: 2]),
            .pwm         (pwm[c]),
            .busy        (busy[c])
        );
    end

endmodule

// File: tb/tb_motor_pwm_multi.sv
// tb/tb_motor_pwm_multi.sv - self-checking bench for motor_pwm_multi against a cycle-level reference model
module tb_motor_pwm_multi;
    localparam int CH   = 2;
    localparam int P    = 1000;
    localparam int DW   = 10;
    localparam int STEP = 100;
    localparam int DT   = 50;
`ifdef MOTOR_SOFT_RAMP_EN
    localparam bit SOFT = 1'b1;
`else
    localparam bit SOFT = 1'b0;
`endif
    localparam int OFF = 0, DRIVE = 1, BRAKE = 2, GAP = 3;

    logic                clk_100kHz = 1'b0;
    logic                rst = 1'b1;
    logic [2*CH-1:0]     direction;
    logic [DW*CH-1:0]    duty_target;
    logic [2*CH-1:0]     en;
    logic [CH-1:0]       pwm;
    logic                period_sync;
    logic [CH-1:0]       busy;

    always #5 clk_100kHz = ~clk_100kHz;

    motor_pwm_multi #(
        .CHANNELS  (CH),
        .PERIOD    (P),
        .DUTY_W    (DW),
        .RAMP_STEP (STEP),
        .DEADTIME  (DT)
    ) dut (
        .clk_100kHz  (clk_100kHz),
        .rst         (rst),
        .direction   (direction),
        .duty_target (duty_target),
        .en          (en),
        .pwm         (pwm),
        .period_sync (period_sync),
        .busy        (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int t;
    int mode[CH];
    bit fwd[CH];
    int duty[CH];
    int gap_end[CH];
    int hi[CH];
    int zrun, zmax;

    function automatic int tgt_clamp(input int c);
        int v;
        v = int'(duty_target[DW*c +: DW]);
        return (v > P) ? P : v;
    endfunction

    function automatic int approach(input int cur, input int goal);
        if (!SOFT) return goal;
        if (goal > cur) return (goal - cur > STEP) ? cur + STEP : goal;
        return (cur - goal > STEP) ? cur - STEP : goal;
    endfunction

    task automatic model_reset();
        t = 0;
        for (int c = 0; c < CH; c++) begin
            mode[c] = OFF; fwd[c] = 1'b0; duty[c] = 0; gap_end[c] = 0;
        end
    endtask

    task automatic model_tick();
        bit bnd;
        bnd = ((t % P) == P - 1);
        t++;
        for (int c = 0; c < CH; c++) begin
            logic [1:0] d;
            bit mv, f;
            int tc;
            d  = direction[2*c +: 2];
            mv = (d == 2'b11) || (d == 2'b00);
            f  = (d == 2'b11);
            tc = tgt_clamp(c);
            case (mode[c])
                OFF: begin
                    duty[c] = 0;
                    if (mv) begin mode[c] = DRIVE; fwd[c] = f; end
                end
                DRIVE: begin
                    if (!mv) begin
                        mode[c] = OFF; duty[c] = 0;
                    end else if (f != fwd[c]) begin
                        if (SOFT) mode[c] = BRAKE;
                        else begin mode[c] = GAP; gap_end[c] = t + DT; duty[c] = 0; end
                    end else if (bnd) begin
                        duty[c] = approach(duty[c], tc);
                    end
                end
                BRAKE: begin
                    if (!mv) begin
                        mode[c] = OFF; duty[c] = 0;
                    end else if (f == fwd[c]) begin
                        mode[c] = DRIVE;
                    end else if (bnd) begin
                        duty[c] = (duty[c] > STEP) ? duty[c] - STEP : 0;
                        if (duty[c] == 0) begin mode[c] = GAP; gap_end[c] = t + DT; end
                    end
                end
                default: begin
                    duty[c] = 0;
                    if (!mv) mode[c] = OFF;
                    else if (t >= gap_end[c]) begin mode[c] = DRIVE; fwd[c] = f; end
                end
            endcase
        end
    endtask

    function automatic logic [8:0] expect_vec();
        logic [2*CH-1:0] e;
        logic [CH-1:0]   p, b;
        bit act;
        for (int c = 0; c < CH; c++) begin
            act        = (mode[c] == DRIVE) || (mode[c] == BRAKE);
            e[2*c +: 2] = act ? (fwd[c] ? 2'b10 : 2'b01) : 2'b00;
            p[c]       = act && ((t % P) < duty[c]);
            b[c]       = (mode[c] == BRAKE) || (mode[c] == GAP) ||
                         ((mode[c] == DRIVE) && (duty[c] != tgt_clamp(c)));
        end
        return {e, p, ((t % P) == P - 1), b};
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_cycle();
        logic [8:0] obs, expv;
        obs  = {en, pwm, period_sync, busy};
        expv = expect_vec();
        for (int c = 0; c < CH; c++) hi[c] += int'(pwm[c]);
        if (en[1:0] == 2'b00) zrun++;
        else begin
            if (zrun > zmax) zmax = zrun;
            zrun = 0;
        end
        if (n_bad < 40) begin
            n_cmp++;
            assert (obs === expv) else begin
                n_bad++;
                $error("FAIL outputs t=%0d observed=%b expected=%b", t, obs, expv);
            end
            n_cmp++;
            assert ((en[1:0] !== 2'b11) && (en[3:2] !== 2'b11)) else begin
                n_bad++;
                $error("FAIL en_both_legs t=%0d observed=%b expected=no_11_pair", t, en);
            end
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_100kHz);
            model_tick();
            #1;
            check_cycle();
        end
    endtask

    task automatic go_phase(input int ph);
        int guard;
        guard = 0;
        while (((t % P) != ph) && (guard < P)) begin
            step(1);
            guard++;
        end
    endtask

    task automatic cmd(input int c, input logic [1:0] d, input int tgt);
        direction[2*c +: 2]    = d;
        duty_target[DW*c +: DW] = DW'(tgt);
    endtask

    task automatic clear_hi();
        for (int c = 0; c < CH; c++) hi[c] = 0;
    endtask

    task automatic do_async_reset();
        int n;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_outputs", int'({en, pwm, period_sync, busy}), 0);
        repeat (2) @(posedge clk_100kHz);
        #1;
        rst = 1'b0;
        model_reset();
        n = 0;
        while ((period_sync !== 1'b1) && (n < 2 * P)) begin
            step(1);
            n++;
        end
        chk("sync_after_rst", n, P - 1);
    endtask

    initial begin
        int w;
        int r;
        logic [1:0] d;
        direction   = 4'b0101;
        duty_target = '0;
        zrun = 0; zmax = 0;
        clear_hi();
        repeat (3) @(posedge clk_100kHz);
        #1;
        chk("reset_outputs", int'({en, pwm, period_sync, busy}), 0);
        rst = 1'b0;
        model_reset();
        step(5);

        // forward ramp to 500
        cmd(0, 2'b11, 500);
        step(7 * P);
        chk("busy0_settled", int'(busy[0]), 0);
        clear_hi();
        step(P);
        chk("pulse_500", hi[0], 500);

        // reversal with dead time
        go_phase(300);
        zrun = 0; zmax = 0;
        cmd(0, 2'b00, 500);
        step(12 * P);
        chk("dead_gap_len", zmax, DT);
        chk("en0_rev", int'(en[1:0]), 1);

        // halt from RUN at 300, then restart
        cmd(0, 2'b00, 300);
        step(3 * P);
        go_phase(150);
        cmd(0, 2'b01, 300);
        step(1);
        chk("halt_en0", int'(en[1:0]), 0);
        chk("halt_pwm0", int'(pwm[0]), 0);
        step(20);
        cmd(0, 2'b11, 300);
        step(2 * P + 10);

        // clamp above PERIOD
        cmd(0, 2'b11, 1023);
        step(9 * P);
        clear_hi();
        step(P);
        chk("pulse_clamp", hi[0], P);

        // async reset during dead time, then during a ramp
        cmd(1, 2'b11, 300);
        step(4 * P);
        go_phase(200);
        cmd(1, 2'b00, 300);
        w = 0;
        while ((mode[1] != GAP) && (w < 10 * P)) begin
            step(1);
            w++;
        end
        chk("reach_dead_ch1", int'(mode[1] == GAP), 1);
        step(20);
        do_async_reset();
        step(P + 300);
        do_async_reset();

        // ch0 independent of ch1 reversal
        cmd(0, 2'b11, 400);
        cmd(1, 2'b11, 200);
        step(3 * P);
        go_phase(300);
        cmd(1, 2'b00, 200);
        step(5 * P);
        clear_hi();
        step(P);
        chk("ch0_pulse_400", hi[0], 400);
        cmd(1, 2'b00, 0);
        step(3 * P);
        clear_hi();
        step(P);
        chk("ch1_pulse_0", hi[1], 0);

        // randomized commands
        for (int k = 0; k < 6; k++) begin
            go_phase(int'($urandom_range(800, 100)));
            r = int'($urandom_range(2, 0));
            d = (r == 0) ? 2'b11 : ((r == 1) ? 2'b00 : 2'b01);
            cmd(int'($urandom_range(1, 0)), d, int'($urandom_range(1023, 0)));
            step(int'($urandom_range(2, 1)) * P);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
